// File: rtl/card_click_mapper.sv
// card_click_mapper
// Turns a left-button press at a pixel position into a card grid hit or a miss.
// A press is latched in IDLE. The SCAN state then walks the latched offset down one
// pitch per cycle on both axes at once, until the offset lies inside a single card
// cell. A hit is offered on card_* with a valid/ack handshake. A press in a gap or
// outside the grid gives a one-cycle click_miss pulse. After every press the FSM
// waits for the button to be released, so one press reports at most one card.

module card_click_mapper #(
   parameter int COLS     = 4,
   parameter int ROWS     = 4,
   parameter int ORIGIN_X = 64,
   parameter int ORIGIN_Y = 48,
   parameter int CELL_W   = 112,
   parameter int CELL_H   = 88,
   parameter int GAP      = 16,
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int IW      = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic [9:0]    mouse_x,
   input  logic [8:0]    mouse_y,
   input  logic          left_button,
   input  logic          enable,
   input  logic          card_ack,
   output logic          card_valid,
   output logic [IW-1:0] card_index,
   output logic [RW-1:0] card_row,
   output logic [CW-1:0] card_col,
   output logic          click_miss,
   output logic          busy
);

   // Geometry constants. All offset arithmetic is unsigned and 10 bits wide.
   localparam logic [9:0]    PITCH_X  = 10'(CELL_W + GAP);
   localparam logic [9:0]    PITCH_Y  = 10'(CELL_H + GAP);
   localparam logic [9:0]    ORG_X    = 10'(ORIGIN_X);
   localparam logic [9:0]    ORG_Y    = 10'(ORIGIN_Y);
   localparam logic [9:0]    WIDTH_X  = 10'(CELL_W);
   localparam logic [9:0]    HEIGHT_Y = 10'(CELL_H);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD,
      WAIT_REL
   } state_t;

   state_t        state;
   state_t        next_state;

   logic          btn_q;
   logic [9:0]    rem_x;
   logic [9:0]    rem_y;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic          press;
   logic          x_over;
   logic          y_over;
   logic          beyond_grid;
   logic          in_cell;
   logic          outside_origin;
   logic          do_latch;
   logic          do_step_x;
   logic          do_step_y;
   logic          set_hit;
   logic          set_miss;
   logic [IW-1:0] index_calc;

   // A press is a rising edge of the button. It only counts while the game is waiting for input.
   assign press          = left_button & ~btn_q & enable;
   assign outside_origin = (mouse_x < ORG_X) || ({1'b0, mouse_y} < ORG_Y);
   assign x_over         = (rem_x >= PITCH_X);
   assign y_over         = (rem_y >= PITCH_Y);
   assign beyond_grid    = (x_over && (col == COL_LAST)) || (y_over && (row == ROW_LAST));
   assign in_cell        = (rem_x < WIDTH_X) && (rem_y < HEIGHT_Y);
   assign index_calc     = IW'(row) * IW'(COLS) + IW'(col);
   assign busy           = (state != IDLE);

   // State register. An asynchronous reset drops any scan or pending card immediately.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the control strobes that drive the datapath.
   always_comb begin
      next_state = state;
      do_latch   = 1'b0;
      do_step_x  = 1'b0;
      do_step_y  = 1'b0;
      set_hit    = 1'b0;
      set_miss   = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               if (outside_origin) begin
                  set_miss   = 1'b1;
                  next_state = WAIT_REL;
               end else begin
                  do_latch   = 1'b1;
                  next_state = SCAN;
               end
            end
         end
         SCAN: begin
            if (beyond_grid) begin
               set_miss   = 1'b1;
               next_state = WAIT_REL;
            end else if (x_over || y_over) begin
               do_step_x = x_over;
               do_step_y = y_over;
            end else if (in_cell) begin
               set_hit    = 1'b1;
               next_state = HOLD;
            end else begin
               set_miss   = 1'b1;
               next_state = WAIT_REL;
            end
         end
         HOLD: begin
            if (card_ack) begin
               next_state = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!left_button) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Button history. It is sampled every cycle so that a held button never looks like a new press.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         btn_q <= 1'b0;
      end else begin
         btn_q <= left_button;
      end
   end

   // Scan datapath: the offset is latched on a press, then reduced by one pitch per step.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rem_x <= '0;
         rem_y <= '0;
         col   <= '0;
         row   <= '0;
      end else if (do_latch) begin
         rem_x <= mouse_x - ORG_X;
         rem_y <= {1'b0, mouse_y} - ORG_Y;
         col   <= '0;
         row   <= '0;
      end else begin
         if (do_step_x) begin
            rem_x <= rem_x - PITCH_X;
            col   <= col + CW'(1);
         end
         if (do_step_y) begin
            rem_y <= rem_y - PITCH_Y;
            row   <= row + RW'(1);
         end
      end
   end

   // Registered result outputs. card_* stay stable in HOLD; click_miss lasts a single cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         card_valid <= 1'b0;
         card_index <= '0;
         card_row   <= '0;
         card_col   <= '0;
         click_miss <= 1'b0;
      end else begin
         click_miss <= set_miss;
         if (set_hit) begin
            card_valid <= 1'b1;
            card_index <= index_calc;
            card_row   <= row;
            card_col   <= col;
         end else if ((state == HOLD) && card_ack) begin
            card_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_card_click_mapper.sv
// tb_card_click_mapper
// Directed bench for card_click_mapper with the default 4x4 grid geometry.
// A vector table covers hits, gaps, off-grid presses and cell edges.
// Hand-written sequences cover the handshake, press qualification and reset in mid-operation.

module tb_card_click_mapper;

   logic       clock = 1'b0;
   logic       resetn;
   logic [9:0] mouse_x;
   logic [8:0] mouse_y;
   logic       left_button;
   logic       enable;
   logic       card_ack;
   logic       card_valid;
   logic [3:0] card_index;
   logic [1:0] card_row;
   logic [1:0] card_col;
   logic       click_miss;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int x;
      int y;
      bit hit;
      int row;
      int col;
      int index;
      int lat;
   } vec_t;

   vec_t vecs[11];

   card_click_mapper dut (
      .clock       (clock),
      .resetn      (resetn),
      .mouse_x     (mouse_x),
      .mouse_y     (mouse_y),
      .left_button (left_button),
      .enable      (enable),
      .card_ack    (card_ack),
      .card_valid  (card_valid),
      .card_index  (card_index),
      .card_row    (card_row),
      .card_col    (card_col),
      .click_miss  (click_miss),
      .busy        (busy)
   );

   // 50 MHz system clock.
   always #10 clock = ~clock;

   // Safety net so that the run always ends, even if the design locks up.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one cycle. Outputs are sampled and inputs changed 1 ns after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Return to a quiet idle state with the button released.
   task automatic settle();
      left_button = 1'b0;
      card_ack    = 1'b0;
      tick();
      tick();
   endtask

   // Press the button at (x,y). Return the number of edges until card_valid or click_miss rises.
   // lat is -1 if neither output rises within the cycle budget.
   task automatic pressAndWait(input int x, input int y, output int lat, output bit hit);
      mouse_x     = 10'(x);
      mouse_y     = 9'(y);
      left_button = 1'b1;
      lat = -1;
      hit = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (card_valid && click_miss) begin
            checkOutput("valid_and_miss_exclusive", 1, 0);
         end
         if (card_valid || click_miss) begin
            lat = c;
            hit = card_valid;
            break;
         end
      end
   endtask

   // Apply one table vector. Check its outcome, latency and card fields, then finish the handshake.
   task automatic applyStimulus(input int n, input vec_t v);
      int lat;
      bit hit;
      enable = 1'b1;
      settle();
      pressAndWait(v.x, v.y, lat, hit);
      checkOutput($sformatf("v%0d_latency", n), lat, v.lat);
      checkOutput($sformatf("v%0d_is_hit", n), int'(hit), int'(v.hit));
      if (v.hit) begin
         checkOutput($sformatf("v%0d_row", n), int'(card_row), v.row);
         checkOutput($sformatf("v%0d_col", n), int'(card_col), v.col);
         checkOutput($sformatf("v%0d_index", n), int'(card_index), v.index);
         tick();
         checkOutput($sformatf("v%0d_valid_held", n), int'(card_valid), 1);
         card_ack = 1'b1;
         tick();
         checkOutput($sformatf("v%0d_valid_after_ack", n), int'(card_valid), 0);
         card_ack = 1'b0;
      end else begin
         tick();
         checkOutput($sformatf("v%0d_miss_one_cycle", n), int'(click_miss), 0);
         checkOutput($sformatf("v%0d_no_card", n), int'(card_valid), 0);
      end
      settle();
      checkOutput($sformatf("v%0d_idle_busy", n), int'(busy), 0);
   endtask

   initial begin
      int  lat;
      bit  hit;
      int  seen;

      // Offsets relative to the origin (64,48). The pitch is 128 in x and 104 in y.
      vecs[0]  = '{x: 70,  y: 50,  hit: 1'b1, row: 0, col: 0, index: 0,  lat: 2};
      vecs[1]  = '{x: 320, y: 200, hit: 1'b1, row: 1, col: 2, index: 6,  lat: 4};
      vecs[2]  = '{x: 200, y: 145, hit: 1'b0, row: 0, col: 0, index: 0,  lat: 3};
      vecs[3]  = '{x: 30,  y: 100, hit: 1'b0, row: 0, col: 0, index: 0,  lat: 1};
      vecs[4]  = '{x: 600, y: 100, hit: 1'b0, row: 0, col: 0, index: 0,  lat: 5};
      vecs[5]  = '{x: 559, y: 447, hit: 1'b1, row: 3, col: 3, index: 15, lat: 5};
      vecs[6]  = '{x: 176, y: 100, hit: 1'b0, row: 0, col: 0, index: 0,  lat: 2};
      vecs[7]  = '{x: 64,  y: 48,  hit: 1'b1, row: 0, col: 0, index: 0,  lat: 2};
      vecs[8]  = '{x: 63,  y: 48,  hit: 1'b0, row: 0, col: 0, index: 0,  lat: 1};
      vecs[9]  = '{x: 192, y: 152, hit: 1'b1, row: 1, col: 1, index: 5,  lat: 3};
      vecs[10] = '{x: 100, y: 479, hit: 1'b0, row: 0, col: 0, index: 0,  lat: 5};

      resetn      = 1'b0;
      mouse_x     = '0;
      mouse_y     = '0;
      left_button = 1'b0;
      enable      = 1'b0;
      card_ack    = 1'b0;
      tick();
      checkOutput("reset_card_valid", int'(card_valid), 0);
      checkOutput("reset_click_miss", int'(click_miss), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_card_index", int'(card_index), 0);
      resetn = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Moving the pointer during the scan must not change the result.
      enable = 1'b1;
      settle();
      mouse_x     = 10'd320;
      mouse_y     = 9'd200;
      left_button = 1'b1;
      tick();
      mouse_x = 10'd600;
      mouse_y = 9'd20;
      pressAndWait(600, 20, lat, hit);
      checkOutput("moved_latency", lat + 1, 4);
      checkOutput("moved_col", int'(card_col), 2);
      checkOutput("moved_row", int'(card_row), 1);
      checkOutput("moved_index", int'(card_index), 6);

      // Acknowledge with the button still held. A second card must not appear.
      card_ack = 1'b1;
      tick();
      card_ack = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (card_valid || click_miss) seen++;
      end
      checkOutput("held_no_second_card", seen, 0);
      checkOutput("held_busy_wait_rel", int'(busy), 1);

      // A press while enable=0 is dropped and is not queued for later.
      enable = 1'b0;
      settle();
      mouse_x     = 10'd70;
      mouse_y     = 9'd50;
      left_button = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (card_valid || click_miss || busy) seen++;
      end
      checkOutput("disabled_press_ignored", seen, 0);
      enable = 1'b1;
      tick();
      checkOutput("enable_without_new_press", int'(busy), 0);
      settle();
      pressAndWait(70, 50, lat, hit);
      checkOutput("reenabled_press_latency", lat, 2);
      checkOutput("reenabled_press_hit", int'(hit), 1);
      card_ack = 1'b1;
      tick();
      card_ack = 1'b0;
      settle();

      // With card_ack held high from before the press, card_valid lasts exactly one cycle.
      card_ack = 1'b1;
      tick();
      mouse_x     = 10'd70;
      mouse_y     = 9'd50;
      left_button = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (card_valid) seen++;
      end
      checkOutput("ack_held_valid_cycles", seen, 1);
      settle();

      // Reset asserted during SCAN.
      mouse_x     = 10'd320;
      mouse_y     = 9'd200;
      left_button = 1'b1;
      tick();
      tick();
      checkOutput("scan_busy_before_reset", int'(busy), 1);
      resetn = 1'b0;
      #1;
      checkOutput("scan_reset_busy", int'(busy), 0);
      checkOutput("scan_reset_valid", int'(card_valid), 0);
      left_button = 1'b0;
      tick();
      resetn = 1'b1;
      tick();

      // Reset asserted during HOLD drops the pending card.
      mouse_x     = 10'd192;
      mouse_y     = 9'd152;
      left_button = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("hold_valid_before_reset", int'(card_valid), 1);
      resetn = 1'b0;
      #1;
      checkOutput("hold_reset_valid", int'(card_valid), 0);
      checkOutput("hold_reset_busy", int'(busy), 0);
      checkOutput("hold_reset_index", int'(card_index), 0);
      left_button = 1'b0;
      tick();
      resetn = 1'b1;
      tick();

      // After reset, a normal press works again.
      applyStimulus(100, vecs[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
